sobol_path_sequencer: RTL

Request-side driver for the Sobol generator. It walks path index × time-step dimension and issues one draw request per cycle on the generator's valid/N/dim interface. It collects the generator's returned words, which come back with no backpressure, into a credit-protected FIFO. It then presents the words, tagged with path/dim/last, on a ready/valid stream to the downstream normal-transform / GBM path stage.

---
 rtl/fpga_cfg_pkg.sv | 11 +
 rtl/sobol_path_sequencer_pkg.sv | 25 ++
 rtl/sobol_path_sequencer_fifo.sv | 74 +++++++
 rtl/sobol_path_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | fpga_cfg_pkg : platform-wide datapath width and dimension limit      |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package fpga_cfg_pkg;
  localparam int FP_WIDTH = 32;
  localparam int MAX_DIMS = 50;
endpackage
`default_nettype wire

// File: rtl/sobol_path_sequencer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | sobol_path_sequencer_pkg : shared element tag and sequencer states   |
// | Revision                 : 1.0                                        |
// +----------------------------------------------------------------------+
package sobol_path_sequencer_pkg;
  import fpga_cfg_pkg::*;

  localparam int TAG_DIM_W = $clog2(MAX_DIMS);

  typedef struct packed {
    logic [FP_WIDTH-1:0]  path;
    logic [TAG_DIM_W-1:0] dim;
    logic                 last;
  } sobol_tag_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } seq_state_t;
endpackage
`default_nettype wire

// File: rtl/sobol_path_sequencer_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, registered storage, show-ahead head   |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule
`default_nettype wire

// File: rtl/sobol_path_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | sobol_path_sequencer : drives Sobol draw requests path-major, buffers|
// |                        results and streams them out with path tags   |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
module sobol_path_sequencer
  import sobol_path_sequencer_pkg::*;
#(
  parameter int WIDTH      = fpga_cfg_pkg::FP_WIDTH,
  parameter int M          = fpga_cfg_pkg::MAX_DIMS,
  parameter int GEN_LAT    = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       num_paths,
  input  logic [$clog2(M+1)-1:0] num_steps,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   gen_valid_in,
  output logic [WIDTH-1:0]       gen_N,
  output logic [$clog2(M)-1:0]   gen_dim,
  input  logic                   gen_valid_out,
  input  logic [WIDTH-1:0]       gen_sobol,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [WIDTH-1:0]       out_path,
  output logic [$clog2(M)-1:0]   out_dim,
  output logic                   out_last
);
  localparam int DW = $clog2(M);
  localparam int SW = $clog2(M + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] path;
    logic [DW-1:0]    dim;
    logic             last;
  } tag_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    tag_t             tag;
  } entry_t;

  seq_state_t           state_q, state_d;
  logic [WIDTH-1:0]     paths_q, paths_d;
  logic [SW-1:0]        steps_q, steps_d;
  logic [WIDTH-1:0]     path_q, path_d;
  logic [DW-1:0]        dim_q, dim_d;
  logic                 err_q, err_d;
  logic [GEN_LAT-1:0]   mask_q, mask_d;
  logic [GEN_LAT-1:0]   tag_vld_q, tag_vld_d;
  tag_t [GEN_LAT-1:0]   tag_q, tag_d;

  logic                 req;
  logic                 last_dim, last_req, credit_ok;
  logic                 tag_out_vld;
  int                   occ;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  entry_t               fifo_din, fifo_dout;

  assign tag_out_vld = tag_vld_q[GEN_LAT-1];
  assign last_dim    = (SW'(dim_q) == steps_q - SW'(1));
  assign last_req    = last_dim && (path_q == paths_q - WIDTH'(1));

  // Budget against the tag leaving the pipe rather than the actual push so
  // request issue never depends combinationally on gen_valid_out.
  always_comb begin
    occ = int'(fifo_count) + int'(tag_out_vld);
    for (int i = 0; i < GEN_LAT - 1; i++) begin
      occ = occ + int'(tag_vld_q[i]);
    end
    credit_ok = (occ < FIFO_DEPTH) && !fifo_full;
  end

  always_comb begin
    state_d = state_q;
    paths_d = paths_q;
    steps_d = steps_q;
    path_d  = path_q;
    dim_d   = dim_q;
    req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          paths_d = num_paths;
          steps_d = num_steps;
          path_d  = '0;
          dim_d   = '0;
          state_d = (num_paths == '0 || num_steps == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (credit_ok) begin
          req = 1'b1;
          if (last_dim) begin
            dim_d  = '0;
            path_d = path_q + WIDTH'(1);
          end else begin
            dim_d = dim_q + DW'(1);
          end
          if (last_req) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Second term recovers if the final result was lost to a generator fault.
        if ((fifo_pop && fifo_dout.tag.last) || (fifo_empty && tag_vld_q == '0)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tag_d     = tag_q;
    tag_vld_d = tag_vld_q;
    for (int i = GEN_LAT - 1; i > 0; i--) begin
      tag_d[i]     = tag_q[i-1];
      tag_vld_d[i] = tag_vld_q[i-1];
    end
    tag_vld_d[0]     = req;
    tag_d[0].path    = path_q;
    tag_d[0].dim     = dim_q;
    tag_d[0].last    = last_req;
    mask_d           = mask_q >> 1;
    // Results still flying when reset hit have no tag; the mask hides them.
    err_d            = err_q | (!mask_q[0] && (tag_out_vld != gen_valid_out));
    fifo_push        = tag_out_vld && gen_valid_out;
    fifo_din.data    = gen_sobol;
    fifo_din.tag     = tag_q[GEN_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      paths_q   <= '0;
      steps_q   <= '0;
      path_q    <= '0;
      dim_q     <= '0;
      err_q     <= 1'b0;
      mask_q    <= '1;
      tag_vld_q <= '0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      paths_q   <= paths_d;
      steps_q   <= steps_d;
      path_q    <= path_d;
      dim_q     <= dim_d;
      err_q     <= err_d;
      mask_q    <= mask_d;
      tag_vld_q <= tag_vld_d;
      tag_q     <= tag_d;
    end
  end

  sync_fifo #(
    .DATA_W ($bits(entry_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign fifo_pop     = out_valid && out_ready;
  assign out_valid    = !fifo_empty;
  assign out_data     = fifo_empty ? '0 : fifo_dout.data;
  assign out_path     = fifo_empty ? '0 : fifo_dout.tag.path;
  assign out_dim      = fifo_empty ? '0 : fifo_dout.tag.dim;
  assign out_last     = !fifo_empty && fifo_dout.tag.last;
  assign gen_valid_in = req;
  assign gen_N        = req ? (path_q + WIDTH'(1)) : '0;
  assign gen_dim      = req ? dim_q : '0;
  assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_FIN);
  assign err          = err_q;
endmodule
`default_nettype wire
